// File: rtl/adapter_axi_stream_2_ppfifo.sv
// AXI Stream ingress adapter: packs accepted beats into one-hot ping-pong FIFO write buffers.
// Optional build macro ADAPTER_AXI_STREAM_2_PPFIFO_KEEP_FILTER_EN drops beats with tkeep==0.
module adapter_axi_stream_2_ppfifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int STROBE_WIDTH       = DATA_WIDTH / 8,
  parameter int MAP_USER_TO_PPFIFO = 1,
  parameter int USER_COUNT         = 1
) (
  input  logic                             i_axi_clk,
  input  logic                             rst_n,
  input  logic [3:0]                       i_axi_user,
  input  logic [DATA_WIDTH-1:0]            i_axi_data,
  input  logic [STROBE_WIDTH-1:0]          i_axi_keep,
  input  logic                             i_axi_last,
  input  logic                             i_axi_valid,
  output logic                             o_axi_ready,
  input  logic [1:0]                       i_ppfifo_rdy,
  output logic [1:0]                       o_ppfifo_act,
  input  logic [23:0]                      i_ppfifo_size,
  output logic                             o_ppfifo_stb,
  output logic [DATA_WIDTH+USER_COUNT-1:0] o_ppfifo_data
);

  typedef enum logic [1:0] {IDLE, READY, RELEASE} state_t;

  state_t                           r_state, w_state_nxt;
  logic [1:0]                       r_act, w_act_nxt;
  logic [23:0]                      r_count, w_count_nxt;
  logic                             r_stb, w_stb_nxt;
  logic [DATA_WIDTH+USER_COUNT-1:0] r_data, w_data_nxt;
  logic                             w_ready, w_accept, w_write;
  logic [USER_COUNT-1:0]            w_user;
  logic [23:0]                      w_count_inc;
  logic                             w_unused;

  assign w_user = (MAP_USER_TO_PPFIFO != 0) ? i_axi_user[USER_COUNT-1:0] : '0;

  // Gated by rst_n so no handshake can complete on the edge that resets the buffer.
  assign w_ready     = rst_n && (r_state == READY) && (r_count < i_ppfifo_size);
  assign w_accept    = i_axi_valid && w_ready;
  assign w_count_inc = r_count + 24'd1;

`ifdef ADAPTER_AXI_STREAM_2_PPFIFO_KEEP_FILTER_EN
  assign w_write  = w_accept && (i_axi_keep != '0);
  assign w_unused = ^i_axi_user;
`else
  assign w_write  = w_accept;
  assign w_unused = ^{i_axi_keep, i_axi_user};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_act_nxt   = r_act;
    w_count_nxt = r_count;
    w_stb_nxt   = 1'b0;
    w_data_nxt  = r_data;
    case (r_state)
      IDLE: begin
        if ((r_act == 2'b00) && (i_ppfifo_rdy != 2'b00)) begin
          w_act_nxt   = i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
          w_count_nxt = '0;
          w_state_nxt = READY;
        end
      end
      READY: begin
        if (r_count >= i_ppfifo_size) begin
          w_state_nxt = RELEASE;
        end else if (w_accept) begin
          if (w_write) begin
            w_stb_nxt   = 1'b1;
            w_data_nxt  = {w_user, i_axi_data};
            w_count_nxt = w_count_inc;
          end
          // act stays high through RELEASE so the final strobe lands inside the buffer.
          if (i_axi_last || (w_write && (w_count_inc >= i_ppfifo_size)))
            w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        w_act_nxt   = 2'b00;
        w_state_nxt = IDLE;
      end
      default: begin
        w_act_nxt   = 2'b00;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_axi_clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_act   <= 2'b00;
      r_count <= '0;
      r_stb   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_act   <= w_act_nxt;
      r_count <= w_count_nxt;
      r_stb   <= w_stb_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign o_axi_ready   = w_ready;
  assign o_ppfifo_act  = r_act;
  assign o_ppfifo_stb  = r_stb;
  assign o_ppfifo_data = r_data;

endmodule

// File: tb/tb_adapter_axi_stream_2_ppfifo.sv
// Directed scoreboard bench for adapter_axi_stream_2_ppfifo with a small ping-pong FIFO ready model.
module tb_adapter_axi_stream_2_ppfifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  i_axi_user = '0;
  logic [31:0] i_axi_data = '0;
  logic [3:0]  i_axi_keep = '0;
  logic        i_axi_last = 1'b0;
  logic        i_axi_valid = 1'b0;
  logic        o_axi_ready;
  logic [1:0]  ppf_rdy = 2'b00;
  logic [1:0]  o_ppfifo_act;
  logic [23:0] ppf_size = 24'd8;
  logic        o_ppfifo_stb;
  logic [32:0] o_ppfifo_data;

  adapter_axi_stream_2_ppfifo #(
    .DATA_WIDTH(32), .MAP_USER_TO_PPFIFO(1), .USER_COUNT(1)
  ) dut (
    .i_axi_clk(clk), .rst_n(rst_n), .i_axi_user(i_axi_user), .i_axi_data(i_axi_data),
    .i_axi_keep(i_axi_keep), .i_axi_last(i_axi_last), .i_axi_valid(i_axi_valid),
    .o_axi_ready(o_axi_ready), .i_ppfifo_rdy(ppf_rdy), .o_ppfifo_act(o_ppfifo_act),
    .i_ppfifo_size(ppf_size), .o_ppfifo_stb(o_ppfifo_stb), .o_ppfifo_data(o_ppfifo_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [32:0] expq[$];
  logic [32:0] got_q[$];
  logic [1:0] rdy_cfg = 2'b00;
  logic       model_en = 1'b0;
  logic [1:0] prev_act = 2'b00;
  logic [1:0] rel_buf = 2'b00;
  logic [1:0] stb_act = 2'b00;
  int cur_cnt = 0;
  int rel_cnt = 0;
  int n_rel = 0;
  int stb_total = 0;

  // Output collector plus ping-pong reader model: a released buffer goes not-ready,
  // the other buffer becomes ready again once a new buffer is activated.
  always @(negedge clk) begin
    if (o_ppfifo_stb) begin
      got_q.push_back(o_ppfifo_data);
      stb_total++;
      cur_cnt++;
      stb_act = o_ppfifo_act;
    end
    if (prev_act != 2'b00 && o_ppfifo_act == 2'b00) begin
      rel_buf = prev_act;
      rel_cnt = cur_cnt;
      cur_cnt = 0;
      n_rel++;
      if (model_en) ppf_rdy = ppf_rdy & ~prev_act;
    end
    if (prev_act == 2'b00 && o_ppfifo_act != 2'b00 && model_en)
      ppf_rdy = ppf_rdy | ~o_ppfifo_act;
    if (!model_en) ppf_rdy = rdy_cfg;
    prev_act = o_ppfifo_act;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] exp_word(input logic [31:0] d, input logic [3:0] u);
    return {u[0], d};
  endfunction

  function automatic bit beat_writes(input logic [3:0] k);
`ifdef ADAPTER_AXI_STREAM_2_PPFIFO_KEEP_FILTER_EN
    return (k != 4'h0);
`else
    return (k == k);
`endif
  endfunction

  task automatic do_reset(input logic [23:0] size, input logic [1:0] cfg, input logic en);
    i_axi_valid = 1'b0;
    i_axi_last  = 1'b0;
    model_en    = 1'b0;
    rdy_cfg     = cfg;
    ppf_size    = size;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_act", o_ppfifo_act, 2'b00);
    check("rst_stb", o_ppfifo_stb, 1'b0);
    check("rst_ready", o_axi_ready, 1'b0);
    check("rst_data", o_ppfifo_data, 33'h0);
    model_en = en;
    rst_n    = 1'b1;
  endtask

  // Drives one beat from a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [3:0] u, input logic [3:0] k,
                      input logic l, output int waits);
    bit ok = 1'b0;
    bit wr = beat_writes(k);
    waits = 0;
    i_axi_data  = d;
    i_axi_user  = u;
    i_axi_keep  = k;
    i_axi_last  = l;
    i_axi_valid = 1'b1;
    while (!ok && waits < 64) begin
      #1;
      if (o_axi_ready) begin
        ok = 1'b1;
        if (wr) expq.push_back(exp_word(d, u));
      end
      @(negedge clk);
      if (!ok) waits++;
    end
    i_axi_valid = 1'b0;
    i_axi_last  = 1'b0;
    if (!ok) check("ready_timeout", 64'd0, 64'd1);
    else if (wr) check("stb_latency", o_ppfifo_stb, 1'b1);
  endtask

  task automatic compare_all(input string tag);
    int ng = got_q.size();
    int ne = expq.size();
    check({tag, "_count"}, ng, ne);
    while (got_q.size() > 0 && expq.size() > 0)
      check({tag, "_word"}, got_q.pop_front(), expq.pop_front());
    got_q.delete();
    expq.delete();
  endtask

  initial begin
    int w;
    int waits[20];
    int nz;
    int base_rel;
    int base_stb;
    int rhi;

    // Single buffer closed by tlast on the eighth beat.
    do_reset(24'd8, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) send(i, 4'h0, 4'hF, (i == 7), w);
    check("t1_ready_after_last", o_axi_ready, 1'b0);
    check("t1_act_at_final_stb", o_ppfifo_act, 2'b01);
    @(negedge clk);
    check("t1_act_dropped", o_ppfifo_act, 2'b00);
    @(negedge clk);
    check("t1_rel_cnt", rel_cnt, 8);
    check("t1_rel_buf", rel_buf, 2'b01);
    compare_all("t1");

    // Continuous stream across buffer boundaries, no tlast.
    do_reset(24'd8, 2'b11, 1'b1);
    base_rel = n_rel;
    for (int i = 0; i < 20; i++) send(32'd100 + i, 4'h0, 4'hF, 1'b0, waits[i]);
    repeat (2) @(negedge clk);
    check("t2_gap_b0", (waits[8] >= 2), 1'b1);
    check("t2_gap_b1", (waits[16] >= 2), 1'b1);
    nz = 0;
    for (int i = 1; i < 20; i++) if (i != 8 && i != 16 && waits[i] != 0) nz++;
    check("t2_no_mid_stall", nz, 0);
    check("t2_releases", n_rel - base_rel, 2);
    check("t2_second_buf", rel_buf, 2'b10);
    check("t2_third_buf_act", o_ppfifo_act, 2'b01);
    check("t2_third_fill", cur_cnt, 4);
    compare_all("t2");

    // tlast closes a large buffer early; next beat lands in the other buffer.
    do_reset(24'd16, 2'b11, 1'b1);
    base_rel = n_rel;
    for (int i = 0; i < 5; i++) send(32'hA0 + i, 4'h0, 4'hF, (i == 4), w);
    send(32'hB0, 4'h0, 4'hF, 1'b0, w);
    repeat (2) @(negedge clk);
    check("t3_rel_cnt", rel_cnt, 5);
    check("t3_rel_buf", rel_buf, 2'b01);
    check("t3_releases", n_rel - base_rel, 1);
    check("t3_next_buf", stb_act, 2'b10);
    compare_all("t3");

    // Reset in the middle of a buffer, then a fresh full buffer.
    do_reset(24'd8, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) send(32'hC0 + i, 4'h0, 4'hF, 1'b0, w);
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_act", o_ppfifo_act, 2'b00);
    check("t4_stb", o_ppfifo_stb, 1'b0);
    check("t4_ready", o_axi_ready, 1'b0);
    rst_n = 1'b1;
    compare_all("t4a");
    for (int i = 0; i < 8; i++) send(32'hD0 + i, 4'h0, 4'hF, (i == 7), w);
    repeat (2) @(negedge clk);
    check("t4_fresh_cnt", rel_cnt, 8);
    compare_all("t4b");

    // tuser mapping: only bit 0 carried, upper bits dropped.
    do_reset(24'd8, 2'b01, 1'b0);
    send(32'h0, 4'h1, 4'hF, 1'b0, w);
    send(32'h1, 4'hE, 4'hF, 1'b0, w);
    send(32'h2, 4'hE, 4'hF, 1'b0, w);
    send(32'h3, 4'h0, 4'hF, 1'b1, w);
    repeat (2) @(negedge clk);
    compare_all("t5");

    // Null (keep==0) beats, the last one carrying tlast.
    do_reset(24'd8, 2'b01, 1'b0);
    base_rel = n_rel;
    send(32'hE0, 4'h0, 4'hF, 1'b0, w);
    send(32'hE1, 4'h0, 4'h0, 1'b0, w);
    send(32'hE2, 4'h0, 4'hF, 1'b0, w);
    send(32'hE3, 4'h0, 4'h0, 1'b1, w);
    repeat (2) @(negedge clk);
    check("t6_released", n_rel - base_rel, 1);
`ifdef ADAPTER_AXI_STREAM_2_PPFIFO_KEEP_FILTER_EN
    check("t6_rel_cnt", rel_cnt, 2);
`else
    check("t6_rel_cnt", rel_cnt, 4);
`endif
    compare_all("t6");

    // Zero-size buffers: never ready, no strobes, buffers still cycle.
    do_reset(24'd0, 2'b01, 1'b0);
    base_rel = n_rel;
    base_stb = stb_total;
    rhi = 0;
    i_axi_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (o_axi_ready) rhi++;
      @(negedge clk);
    end
    i_axi_valid = 1'b0;
    check("t7_ready_hi", rhi, 0);
    check("t7_stb", stb_total - base_stb, 0);
    check("t7_releases", (n_rel - base_rel >= 2), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
